// File: rtl/wt_cache_pkg.sv
// Shared types and constants for the write-through data-cache replacement logic.
//   DCACHE_NUM_WORDS / DCACHE_SET_ASSOC : default cache geometry (sets, ways)
//   upd_op_e                            : operation on the replacement-state update port
//   repl_state_e                        : replacement controller FSM states
//   sat_add8                            : 8-bit saturating add used by the drop counter
package wt_cache_pkg;

  localparam int unsigned DCACHE_NUM_WORDS = 256;
  localparam int unsigned DCACHE_SET_ASSOC = 4;

  typedef enum logic [1:0] {
    UPD_INIT = 2'd0,
    UPD_HIT  = 2'd1,
    UPD_FILL = 2'd2
  } upd_op_e;

  typedef enum logic {
    ST_FLUSH = 1'b0,
    ST_IDLE  = 1'b1
  } repl_state_e;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? 8'hff : sum[7:0];
  endfunction

endpackage

// File: rtl/wt_dcache_repl_fifo.sv
// Hit-update queue for the replacement controller.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : synchronous clear, discards all entries
//   push_i/data_i : enqueue (accepted when not full, or when a pop happens the same cycle)
//   pop_i/data_o  : dequeue; data_o shows the head combinationally
//   full_o/empty_o: occupancy flags
// Depth must be a power of two (>= 2) so the pointers wrap naturally.
module wt_dcache_repl_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  rd_ptr_reg;
  logic [PtrW-1:0]  wr_ptr_reg;
  logic [CntW-1:0]  cnt_reg;
  logic             pop_ok;
  logic             push_ok;

  assign full_o  = (cnt_reg == CntW'(Depth));
  assign empty_o = (cnt_reg == '0);

  // Pop is evaluated first, so a full queue still accepts a push in a pop cycle.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Head is read combinationally: the controller issues the HIT update in the
  // same cycle it decides to pop.
  assign data_o = mem[rd_ptr_reg];

  always_ff @(posedge clk_i) begin
    if (push_ok && !clr_i) begin
      mem[wr_ptr_reg] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else if (clr_i) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt_reg <= cnt_reg + 1'b1;
        2'b01:   cnt_reg <= cnt_reg - 1'b1;
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

endmodule

// File: rtl/wt_dcache_repl_ctrl.sv
// Replacement-state controller for the write-through data cache.
// Owns the single update port of the replacement-state array and arbitrates
// between a full INIT sweep (FLUSH), victim requests (FILL) and queued hit
// updates (HIT).
//   clk_i, rst_ni                    : clock, asynchronous active-low reset
//   flush_i / flush_ack_o            : flush request / one-cycle completion pulse
//   hit_valid_i/hit_idx_i/hit_way_i  : per-port hit updates, one queued per cycle (round robin)
//   miss_req_i/miss_idx_i/miss_gnt_o : victim request and same-cycle grant
//   repl_way_i                       : victim way from the array during a FILL
//   victim_valid_o/victim_way_o      : registered victim result, cycle after grant
//   upd_valid_o/upd_op_o/upd_idx_o/upd_way_o : update port to the array
//   busy_o                           : high while sweeping (FLUSH)
//   drop_cnt_o                       : saturating count of dropped hit updates
module wt_dcache_repl_ctrl
  import wt_cache_pkg::*;
#(
  parameter int unsigned NumPorts  = 3,
  parameter int unsigned NumSets   = DCACHE_NUM_WORDS,
  parameter int unsigned FifoDepth = 4,
  parameter int unsigned NumWays   = DCACHE_SET_ASSOC
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic                                       flush_i,
  output logic                                       flush_ack_o,
  input  logic [NumPorts-1:0]                        hit_valid_i,
  input  logic [NumPorts-1:0][$clog2(NumSets)-1:0]   hit_idx_i,
  input  logic [NumPorts-1:0][$clog2(NumWays)-1:0]   hit_way_i,
  input  logic                                       miss_req_i,
  input  logic [$clog2(NumSets)-1:0]                 miss_idx_i,
  output logic                                       miss_gnt_o,
  input  logic [$clog2(NumWays)-1:0]                 repl_way_i,
  output logic                                       victim_valid_o,
  output logic [$clog2(NumWays)-1:0]                 victim_way_o,
  output logic                                       upd_valid_o,
  output logic [1:0]                                 upd_op_o,
  output logic [$clog2(NumSets)-1:0]                 upd_idx_o,
  output logic [$clog2(NumWays)-1:0]                 upd_way_o,
  output logic                                       busy_o,
  output logic [7:0]                                 drop_cnt_o
);

  localparam int unsigned IdxW  = $clog2(NumSets);
  localparam int unsigned WayW  = $clog2(NumWays);
  localparam int unsigned EntW  = IdxW + WayW;
  localparam int unsigned RrW   = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int unsigned DistW = RrW + 1;

  // Registered state
  repl_state_e     state_reg;
  logic [IdxW-1:0] set_cnt_reg;
  logic [RrW-1:0]  rr_reg;
  logic [7:0]      drop_cnt_reg;
  logic            victim_valid_reg;
  logic [WayW-1:0] victim_way_reg;
  logic            flush_ack_reg;

  // Arbitration
  logic [NumPorts-1:0][DistW-1:0] port_dist;
  logic                           win_found;
  logic [RrW-1:0]                 win_port;
  logic [DistW-1:0]               best_dist;
  logic [RrW-1:0]                 rr_next;
  logic [7:0]                     hit_cnt;

  // Update port and queue control
  logic            upd_valid;
  upd_op_e         upd_op;
  logic [IdxW-1:0] upd_idx;
  logic [WayW-1:0] upd_way;
  logic            miss_gnt;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_clr;
  logic            fifo_full;
  logic            fifo_empty;
  logic [EntW-1:0] fifo_head;
  logic [EntW-1:0] fifo_wdata;
  logic [7:0]      drop_inc;

  // Distance of each port from the round-robin pointer; the valid port with
  // the smallest distance wins.
  for (genvar gi = 0; gi < NumPorts; gi++) begin : g_dist
    assign port_dist[gi] = (DistW'(gi) >= DistW'(rr_reg)) ?
                           (DistW'(gi) - DistW'(rr_reg)) :
                           (DistW'(gi + NumPorts) - DistW'(rr_reg));
  end

  always_comb begin
    win_found = 1'b0;
    win_port  = '0;
    best_dist = '1;
    for (int k = 0; k < NumPorts; k++) begin
      if (hit_valid_i[k] && (!win_found || (port_dist[k] < best_dist))) begin
        win_found = 1'b1;
        best_dist = port_dist[k];
        win_port  = RrW'(k);
      end
    end
  end

  assign rr_next    = (win_port == RrW'(NumPorts - 1)) ? '0 : (win_port + 1'b1);
  assign hit_cnt    = 8'($countones(hit_valid_i));
  assign fifo_wdata = {hit_idx_i[win_port], hit_way_i[win_port]};

  always_comb begin
    upd_valid = 1'b0;
    upd_op    = UPD_INIT;
    upd_idx   = '0;
    upd_way   = '0;
    miss_gnt  = 1'b0;
    fifo_pop  = 1'b0;
    fifo_push = 1'b0;
    fifo_clr  = 1'b0;
    drop_inc  = '0;
    if (state_reg == ST_FLUSH) begin
      // Sweep one set per cycle; queued hits are stale, incoming ones dropped.
      upd_valid = 1'b1;
      upd_op    = UPD_INIT;
      upd_idx   = set_cnt_reg;
      fifo_clr  = 1'b1;
      drop_inc  = hit_cnt;
    end else begin
      if (miss_req_i) begin
        miss_gnt  = 1'b1;
        upd_valid = 1'b1;
        upd_op    = UPD_FILL;
        upd_idx   = miss_idx_i;
        upd_way   = repl_way_i;
      end else if (!fifo_empty) begin
        fifo_pop  = 1'b1;
        upd_valid = 1'b1;
        upd_op    = UPD_HIT;
        upd_idx   = fifo_head[EntW-1:WayW];
        upd_way   = fifo_head[WayW-1:0];
      end
      fifo_push = win_found && (!fifo_full || fifo_pop);
      drop_inc  = hit_cnt - 8'(fifo_push);
    end
  end

  wt_dcache_repl_fifo #(
    .Depth (FifoDepth),
    .Width (EntW)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (fifo_clr),
    .push_i  (fifo_push),
    .data_i  (fifo_wdata),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg        <= ST_FLUSH;
      set_cnt_reg      <= '0;
      rr_reg           <= '0;
      drop_cnt_reg     <= '0;
      victim_valid_reg <= 1'b0;
      victim_way_reg   <= '0;
      flush_ack_reg    <= 1'b0;
    end else begin
      flush_ack_reg    <= 1'b0;
      victim_valid_reg <= miss_gnt;
      if (miss_gnt) begin
        victim_way_reg <= repl_way_i;
      end
      drop_cnt_reg <= sat_add8(drop_cnt_reg, drop_inc);
      case (state_reg)
        ST_FLUSH: begin
          if (set_cnt_reg == IdxW'(NumSets - 1)) begin
            state_reg     <= ST_IDLE;
            set_cnt_reg   <= '0;
            flush_ack_reg <= 1'b1;
          end else begin
            set_cnt_reg <= set_cnt_reg + 1'b1;
          end
        end
        ST_IDLE: begin
          if (win_found) begin
            rr_reg <= rr_next;
          end
          if (flush_i) begin
            state_reg   <= ST_FLUSH;
            set_cnt_reg <= '0;
          end
        end
        default: state_reg <= ST_FLUSH;
      endcase
    end
  end

  // The sweep state is also the reset state, so the update port is gated
  // with reset to keep the array untouched while reset is held.
  assign upd_valid_o    = upd_valid & rst_ni;
  assign upd_op_o       = rst_ni ? upd_op : UPD_INIT;
  assign upd_idx_o      = rst_ni ? upd_idx : '0;
  assign upd_way_o      = rst_ni ? upd_way : '0;
  assign miss_gnt_o     = miss_gnt & rst_ni;
  assign busy_o         = (state_reg == ST_FLUSH);
  assign flush_ack_o    = flush_ack_reg;
  assign victim_valid_o = victim_valid_reg;
  assign victim_way_o   = victim_way_reg;
  assign drop_cnt_o     = drop_cnt_reg;

endmodule

// File: doc/wt_dcache_repl_ctrl.md
WT_DCACHE_REPL_CTRL -- requirements
Module: wt_dcache_repl_ctrl

Interface
REQ-001 SHALL have parameter NumPorts, default 3: number of hit-update requesters.
REQ-002 SHALL have parameter NumSets, default DCACHE_NUM_WORDS: sets in the replacement-state array.
REQ-003 SHALL have parameter FifoDepth, default 4: hit-update queue entries, power of two.
REQ-004 SHALL have parameter NumWays, default DCACHE_SET_ASSOC (4).
REQ-005 SHALL use clk_i, input, 1: clock.
REQ-006 SHALL use rst_ni, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have flush_i, input, 1: single-cycle flush request.
REQ-008 SHALL have flush_ack_o, output, 1: single-cycle flush-complete pulse.
REQ-009 SHALL have hit_valid_i, input, NumPorts: per-port hit-update valid.
REQ-010 SHALL have hit_idx_i, input, NumPorts x clog2(NumSets): per-port set index.
REQ-011 SHALL have hit_way_i, input, NumPorts x clog2(NumWays): per-port hit way.
REQ-012 SHALL have miss_req_i, input, 1: victim request, held until granted.
REQ-013 SHALL have miss_idx_i, input, clog2(NumSets): victim set index, stable while miss_req_i is high.
REQ-014 SHALL have miss_gnt_o, output, 1: victim request accepted this cycle.
REQ-015 SHALL have repl_way_i, input, clog2(NumWays): combinational victim way returned by the array for a FILL update.
REQ-016 SHALL have victim_valid_o, output, 1 and victim_way_o, output, clog2(NumWays): registered victim result.
REQ-017 SHALL have upd_valid_o, output, 1, upd_op_o, output, 2 (INIT/HIT/FILL), upd_idx_o, output, clog2(NumSets), and upd_way_o, output, clog2(NumWays): the single update port to the array.
REQ-018 SHALL have busy_o, output, 1: high while in FLUSH.
REQ-019 SHALL have drop_cnt_o, output, 8: saturating count of dropped hit updates.

Function
REQ-020 SHALL implement FSM states FLUSH and IDLE.
REQ-021 SHALL drive INIT with upd_idx_o = set counter in FLUSH, one set per cycle from 0 to NumSets-1.
REQ-022 SHALL, after set NumSets-1, pulse flush_ack_o for 1 cycle and move to IDLE the next cycle.
REQ-023 SHALL, on flush_i in IDLE, enter FLUSH the next cycle with the counter at 0; flush_i SHALL be ignored while in FLUSH.
REQ-024 SHALL, in FLUSH, hold miss_gnt_o=0, clear the FIFO on entry, and drop all hit requests (each counted).
REQ-025 SHALL use update-port priority in IDLE: miss > FIFO head; at most one update per cycle.
REQ-026 SHALL, in IDLE with miss_req_i=1, assert miss_gnt_o and issue FILL with upd_idx_o=miss_idx_i in the same cycle.
REQ-027 SHALL register repl_way_i at a FILL grant; victim_valid_o SHALL pulse in the following cycle with that way.
REQ-028 SHALL, in IDLE with no miss and a non-empty FIFO, pop the head and issue HIT with its idx/way.
REQ-029 SHALL select one valid hit port per cycle by round-robin, with the pointer advancing past the winner; the winner SHALL be pushed if the FIFO is not full.
REQ-030 SHALL drop losing ports and winners that meet a full FIFO, incrementing drop_cnt_o by the number dropped, saturating at 255.
REQ-031 SHALL handle push and pop in the same cycle with the FIFO full: pop first, so the push succeeds.
REQ-032 SHALL, when no update is issued, drive upd_valid_o=0 and hold upd_op_o/idx/way at 0.
REQ-033 SHALL wrap the FIFO read/write pointers modulo FifoDepth and keep an occupancy counter from 0 to FifoDepth.

Reset
REQ-034 SHALL, on rst_ni low, set FSM=FLUSH, set counter=0, empty the FIFO, set the RR pointer=0, and clear drop_cnt_o, victim_valid_o, flush_ack_o and miss_gnt_o.
REQ-035 SHALL perform an automatic FLUSH after reset, ending with one flush_ack_o pulse.
REQ-036 SHALL, on reset asserted mid-FLUSH or mid-queue, discard all in-flight state with no update issued.

Structure
REQ-037 SHALL place the upd_op enum (INIT=0, HIT=1, FILL=2) and the FSM state typedef in wt_cache_pkg.
REQ-038 SHALL implement the hit queue as a sub-module wt_dcache_repl_fifo.

Verification
REQ-039 Reset, then idle inputs: busy_o=1 for NumSets cycles with INIT idx 0..NumSets-1, flush_ack_o pulses once, then busy_o=0.
REQ-040 Miss idx 5 and FIFO holding hit (idx 7, way 2) in the same cycle, repl_way_i=3: FILL idx 5 first, victim_way_o=3 next cycle, then HIT idx 7 way 2.
REQ-041 All 3 ports valid for 1 cycle with an empty FIFO: exactly one pushed (port 0 first after reset) and drop_cnt_o=2; repeat, and port 1 wins.
REQ-042 Miss held 10 cycles with one port hitting every cycle: FIFO fills to 4, further hits dropped, drop_cnt_o climbs, and it saturates at 255 on a long run.
REQ-043 flush_i during miss_req_i: no miss_gnt_o until flush_ack_o, and FILL is granted the cycle after return to IDLE.
REQ-044 Assert rst_ni low mid-FLUSH at set 100: the counter restarts at 0 and no flush_ack_o occurs before the full sweep.
